decode_imm_stage: RTL and testbench
===================================

# decode_imm_stage

Registered decode stage placed between instruction fetch and the 12-to-32 extend unit. It accepts one 32-bit RV32I instruction per handshake and classifies its format. It extracts the raw 12-bit immediate field that the extend unit consumes, plus the 20-bit U/J field and the register indices. A two-entry skid buffer keeps `in_ready` registered, so backpressure from the extender/ALU side never combinationally reaches fetch.

## Interface
Parameters:
- `PC_W`, 32, width of the program-counter sideband carried with each instruction.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous discard of all buffered entries.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered (`!skid_valid`).
- `instr`  in  32  instruction word.
- `pc_in`  in  PC_W  address of `instr`.
- `out_valid`  out  1  decoded entry available.
- `out_ready`  in  1  consumer accepts entry.
- `imm12`  out  12  raw 12-bit immediate field, fed unextended to the extend unit.
- `imm20`  out  20  raw U/J immediate field.
- `fmt`  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- `illegal`  out  1  opcode not in the RV32I base set.
- `rd`, `rs1`, `rs2`  out  5 each  `instr[11:7]`, `[19:15]`, `[24:20]`.
- `pc_out`  out  PC_W  PC of the entry on the outputs.

## Operation
- Opcode is `instr[6:0]`. Format classes:
  - R: `0110011`.
  - I: `0010011`, `0000011`, `1100111`, `0001111`, `1110011`.
  - S: `0100011`.
  - B: `1100011`.
  - U: `0110111`, `0010111`.
  - J: `1101111`.
  - Any other opcode: fmt 7 and `illegal`=1.
- `imm12` per format:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8]}`. This is imm[12:1]; the downstream shift is not performed here.
  - R, U, J, illegal: 0.
- `imm20` per format:
  - U: `instr[31:12]`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21]}`, which is imm[20:1].
  - All others: 0.
- Decode is combinational on the input. The result is stored into the output register or the skid register together with `pc_in`.
- Storage: output register (`out_valid`) plus skid register (`skid_valid`).
  - Accept: `in_valid && in_ready`.
  - Accept while the output register is empty or draining (`!out_valid || out_ready`): the entry goes to the output register.
  - Accept while the output register is held (`out_valid && !out_ready`): the entry goes to the skid register.
  - Skid register full and `out_ready`=1: the skid entry moves to the output register and the skid register empties. No accept is possible that cycle because `in_ready`=0.
- Entries leave in strict arrival order; no loss and no duplication.
- States are EMPTY, ONE (output register only) and FULL (both registers).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE→FULL on accept while held.
  - FULL→ONE on drain.
  - All other combinations stay in the current state.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing
- Latency: an instruction accepted at edge N appears with `out_valid`=1 after edge N, provided it enters the output register directly.
- Throughput is one instruction per cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid register fills and rises the cycle after it drains.
- Reset: every output register is 0 at the first rising edge with `rst_n`=0, and all sampled inputs are ignored while `rst_n`=0.
  - `out_valid`, `skid_valid`, `imm12`, `imm20`, `fmt`, `illegal`, `rd`, `rs1`, `rs2` and `pc_out` are 0.
  - `in_ready`=1.
  - Reset mid-transfer drops both entries.
- `flush`=1 at an edge: both valid bits clear and any simultaneous accept is discarded. The next cycle shows `out_valid`=0 and `in_ready`=1.
- Priority when events coincide: reset > flush > drain/accept.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1, `instr`=0xFFF00093 → `out_valid`=0, `imm12`=0, `fmt`=0, `in_ready`=1. Nothing is captured.
- I-type: `addi x1,x0,-1` = 0xFFF00093 with `out_ready`=1 → next cycle `out_valid`=1, `fmt`=1, `imm12`=0xFFF, `rd`=1, `rs1`=0.
- S and B types:
  - 0x0020A423 (`sw x2,8(x1)`) → `fmt`=2, `imm12`=0x008, `rs1`=1, `rs2`=2.
  - 0xFE000EE3 (`beq x0,x0,-4`) → `fmt`=3, `imm12`=0xFFE.
- U/J and illegal:
  - 0x123450B7 (`lui`) → `fmt`=4, `imm20`=0x12345, `imm12`=0.
  - 0x00000000 → `fmt`=7, `illegal`=1.
- Backpressure:
  - Stimulus: `out_ready`=0; offer A, B, C on consecutive cycles.
  - Required while held: A is on the outputs, B is in the skid register, and `in_ready`=0 from the cycle after B is accepted. C is held at the input and not taken.
  - Required after raising `out_ready`: the outputs show A, B, C on consecutive accepted cycles, with no gaps beyond one cycle and no duplicates.
- Flush: with FULL state and `in_valid`=1, assert `flush` for one cycle → next cycle `out_valid`=0, `in_ready`=1. A new instruction offered afterwards emerges with 1-cycle latency.

Source files
------------

// File: rtl/decode_imm_if.sv
// Handshake and decoded-payload bundle for decode_imm_stage.
// Fetch side: in_valid/in_ready with instr and pc_in.
// Consumer side: out_valid/out_ready with imm12, imm20, fmt, illegal,
// rd, rs1, rs2 and pc_out.
// The slave modport is the decode stage; master is its environment.
interface decode_imm_if #(
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [11:0]     imm12;
  logic [19:0]     imm20;
  logic [2:0]      fmt;
  logic            illegal;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [PC_W-1:0] pc_out;

  modport slave (
    input  in_valid, instr, pc_in, out_ready,
    output in_ready, out_valid, imm12, imm20, fmt, illegal, rd, rs1, rs2, pc_out
  );

  modport master (
    output in_valid, instr, pc_in, out_ready,
    input  in_ready, out_valid, imm12, imm20, fmt, illegal, rd, rs1, rs2, pc_out
  );
endinterface

// File: rtl/decode_imm_stage.sv
// RV32I format classifier and raw-immediate extractor with a two-entry
// skid buffer, so in_ready is a flop and never sees out_ready combinationally.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop all buffered entries
//   bus        : decode_imm_if.slave (fetch handshake in, decoded entry out)
module decode_imm_stage #(
  parameter int unsigned PC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  decode_imm_if.slave       bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [11:0]     imm12;
    logic [19:0]     imm20;
    logic [2:0]      fmt;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  logic   out_valid;
  logic   skid_valid;
  entry_t out_q;
  entry_t skid_q;
  entry_t dec_c;
  logic   accept_c;

  // Pure field extraction; immediates stay unextended for the downstream unit.
  function automatic entry_t decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    entry_t e;
    e         = '0;
    e.rd      = ins[11:7];
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.pc      = pc;
    case (ins[6:0])
      7'b0110011: e.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        e.fmt   = FMT_I;
        e.imm12 = ins[31:20];
      end
      7'b0100011: begin
        e.fmt   = FMT_S;
        e.imm12 = {ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        // imm[12:1]; the x2 scaling happens downstream
        e.fmt   = FMT_B;
        e.imm12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
      end
      7'b0110111, 7'b0010111: begin
        e.fmt   = FMT_U;
        e.imm20 = ins[31:12];
      end
      7'b1101111: begin
        // imm[20:1]
        e.fmt   = FMT_J;
        e.imm20 = {ins[31], ins[19:12], ins[20], ins[30:21]};
      end
      default: begin
        e.fmt     = FMT_ILL;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  assign dec_c    = decode(bus.instr, bus.pc_in);
  assign accept_c = bus.in_valid && !skid_valid;

  // Buffer control: output register fills first, skid only while output is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            out_q     <= dec_c;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (bus.out_ready) begin
            if (accept_c) begin
              out_q <= dec_c;
            end else begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end else if (accept_c) begin
            skid_q     <= dec_c;
            skid_valid <= 1'b1;
            state      <= FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so no accept can coincide with the drain
          if (bus.out_ready) begin
            out_q      <= skid_q;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = out_valid;
  assign bus.imm12     = out_q.imm12;
  assign bus.imm20     = out_q.imm20;
  assign bus.fmt       = out_q.fmt;
  assign bus.illegal   = out_q.illegal;
  assign bus.rd        = out_q.rd;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.pc_out    = out_q.pc;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: decode vectors, backpressure
// ordering through the skid buffer, flush and reset behaviour.
module tb_decode_imm_stage;
  localparam int unsigned PC_W = 32;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  decode_imm_if #(.PC_W(PC_W)) bus ();

  decode_imm_stage #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.pc_in    = pc;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    offer(32'hFFF00093, 32'h0000_0100);

    // Reset with a live offer: nothing may be captured
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_imm12",     64'(bus.imm12),     64'd0);
    check("rst_fmt",       64'(bus.fmt),       64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_pc_out",    64'(bus.pc_out),    64'd0);

    rst_n = 1'b1;
    // addi x1,x0,-1
    step();
    check("i_valid", 64'(bus.out_valid), 64'd1);
    check("i_fmt",   64'(bus.fmt),       64'd1);
    check("i_imm12", 64'(bus.imm12),     64'hFFF);
    check("i_rd",    64'(bus.rd),        64'd1);
    check("i_rs1",   64'(bus.rs1),       64'd0);
    check("i_pc",    64'(bus.pc_out),    64'h100);

    offer(32'h0020A423, 32'h0000_0104); // sw x2,8(x1)
    step();
    check("s_fmt",   64'(bus.fmt),   64'd2);
    check("s_imm12", 64'(bus.imm12), 64'h008);
    check("s_rs1",   64'(bus.rs1),   64'd1);
    check("s_rs2",   64'(bus.rs2),   64'd2);

    offer(32'hFE000EE3, 32'h0000_0108); // beq x0,x0,-4
    step();
    check("b_fmt",   64'(bus.fmt),   64'd3);
    check("b_imm12", 64'(bus.imm12), 64'hFFE);
    check("b_imm20", 64'(bus.imm20), 64'd0);

    offer(32'h123450B7, 32'h0000_010C); // lui x1,0x12345
    step();
    check("u_fmt",   64'(bus.fmt),   64'd4);
    check("u_imm20", 64'(bus.imm20), 64'h12345);
    check("u_imm12", 64'(bus.imm12), 64'd0);
    check("u_rd",    64'(bus.rd),    64'd1);

    offer(32'h008000EF, 32'h0000_0110); // jal x1,+8
    step();
    check("j_fmt",   64'(bus.fmt),   64'd5);
    check("j_imm20", 64'(bus.imm20), 64'h00004);

    offer(32'h002081B3, 32'h0000_0114); // add x3,x1,x2
    step();
    check("r_fmt",   64'(bus.fmt),     64'd0);
    check("r_ill",   64'(bus.illegal), 64'd0);
    check("r_rd",    64'(bus.rd),      64'd3);

    offer(32'h0000_0000, 32'h0000_0118);
    step();
    check("ill_fmt", 64'(bus.fmt),     64'd7);
    check("ill_bit", 64'(bus.illegal), 64'd1);
    check("ill_pc",  64'(bus.pc_out),  64'h118);

    bus.in_valid = 1'b0;
    step();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: A to output, B to skid, C stalled at the input
    bus.out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0200);
    step();
    check("bp_a_valid", 64'(bus.out_valid), 64'd1);
    check("bp_a_pc",    64'(bus.pc_out),    64'h200);
    check("bp_a_rdy",   64'(bus.in_ready),  64'd1);
    offer(32'h00200313, 32'h0000_0204);
    step();
    check("bp_hold_pc", 64'(bus.pc_out),    64'h200);
    check("bp_full_rdy", 64'(bus.in_ready), 64'd0);
    offer(32'h00300393, 32'h0000_0208);
    step();
    check("bp_hold2_pc",  64'(bus.pc_out),   64'h200);
    check("bp_hold2_rdy", 64'(bus.in_ready), 64'd0);
    check("bp_hold2_rd",  64'(bus.rd),       64'd5);
    bus.out_ready = 1'b1;
    step();
    check("bp_b_pc",    64'(bus.pc_out),    64'h204);
    check("bp_b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_b_rdy",   64'(bus.in_ready),  64'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_c_pc",    64'(bus.pc_out),    64'h208);
    check("bp_c_rd",    64'(bus.rd),        64'd7);
    step();
    check("bp_empty",   64'(bus.out_valid), 64'd0);

    // Flush from FULL with a simultaneous offer that must be discarded
    bus.out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0300);
    step();
    offer(32'h00200313, 32'h0000_0304);
    step();
    check("fl_full_rdy", 64'(bus.in_ready), 64'd0);
    offer(32'h00300393, 32'h0000_0308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_rdy",   64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    offer(32'h123450B7, 32'h0000_030C);
    step();
    bus.in_valid = 1'b0;
    check("fl_new_valid", 64'(bus.out_valid), 64'd1);
    check("fl_new_pc",    64'(bus.pc_out),    64'h30C);
    check("fl_new_fmt",   64'(bus.fmt),       64'd4);
    step();
    check("fl_drained",   64'(bus.out_valid), 64'd0);

    // Reset while FULL drops both entries
    bus.out_ready = 1'b0;
    offer(32'h00100293, 32'h0000_0400);
    step();
    offer(32'h00200313, 32'h0000_0404);
    step();
    rst_n = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("rst2_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_rdy",   64'(bus.in_ready),  64'd1);
    check("rst2_pc",    64'(bus.pc_out),    64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("rst2_idle",  64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
